// File: rtl/sdp_ram_if.sv
// Bus bundle for the pixel-store RAM: host write port plus arbiter read port.
// The master drives addresses/write data; the slave (the RAM) returns rd_data.
interface sdp_ram_if #(
  parameter int ram_width  = 16,
  parameter int data_width = 12
);
  logic [ram_width-1:0]  wr_add;
  logic [data_width-1:0] wr_data;
  logic                  wr_req;
  logic [ram_width-1:0]  rd_add;
  logic [data_width-1:0] rd_data;

  modport master (
    output wr_add, wr_data, wr_req, rd_add,
    input  rd_data
  );

  modport slave (
    input  wr_add, wr_data, wr_req, rd_add,
    output rd_data
  );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port block RAM for 12-bit RGB444 pixels: one write port, one
// registered read port (1-cycle latency, read-first on same-address collision).
module sdp_ram #(
   parameter int ram_width  = 16,
   parameter int data_width = 12
) (
   input  logic     clk,
   input  logic     reset,
   sdp_ram_if.slave bus
);

   localparam int depth = 2 ** ram_width;

   // Power-up contents are all transparent pixels; reset never touches the array.
   logic [data_width-1:0] mem [depth] = '{default: '0};
   logic [data_width-1:0] rd_q;

   // Plain clocked write keeps this mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (reset && bus.wr_req)
         mem[bus.wr_add] <= bus.wr_data;
   end

   // Non-blocking read of the pre-write contents gives read-first collisions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_q <= '0;
      else
         rd_q <= mem[bus.rd_add];
   end

   assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_sdp_ram.sv
// Randomised scoreboard bench for sdp_ram: the driver pushes expected read data
// from an associative-array memory model, the monitor pops one per clock edge.
module tb_sdp_ram;
  localparam int AW = 16;
  localparam int DW = 12;

  logic clk;
  logic reset;

  sdp_ram_if #(.ram_width(AW), .data_width(DW)) bus ();

  sdp_ram #(.ram_width(AW), .data_width(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return '0;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: rd_data=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus, applied on the falling edge.
  task automatic cycle(input string name, input logic r, input logic wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra);
    @(negedge clk);
    reset       = r;
    bus.wr_req  = wr;
    bus.wr_add  = wa;
    bus.wr_data = wd;
    bus.rd_add  = ra;
    if (r) begin
      exp_q.push_back(model_rd(ra));
      tag_q.push_back(name);
      if (wr) model[int'(wa)] = wd;
    end
  endtask

  // Monitor: every edge with reset high yields one read result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, bus.rd_data, e);
      end else if (!reset) begin
        check("rst_hold", bus.rd_data, '0);
      end
    end
  end

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_add  = '0;
    bus.wr_data = '0;
    bus.rd_add  = '0;
    reset       = 1'b1;
    #1 reset    = 1'b0;
    #1 check("rst_async_init", bus.rd_data, '0);

    // Writes while in reset must be dropped.
    cycle("rst_wr", 1'b0, 1'b1, 16'h0040, 12'h777, 16'h0040);
    cycle("rst_wr", 1'b0, 1'b1, 16'h1234, 12'h321, 16'h1234);
    cycle("rst_wr", 1'b0, 1'b0, 16'h0000, 12'h000, 16'h0000);

    cycle("init_rd",    1'b1, 1'b0, 16'h0000, 12'h000, 16'h1234);
    cycle("rst_wr_chk", 1'b1, 1'b0, 16'h0000, 12'h000, 16'h0040);

    cycle("wr_rd",  1'b1, 1'b1, 16'h0010, 12'hABC, 16'h0010);
    cycle("wr_rd",  1'b1, 1'b0, 16'h0000, 12'h000, 16'h0010);

    cycle("coll",   1'b1, 1'b1, 16'h0020, 12'h111, 16'h0000);
    cycle("coll",   1'b1, 1'b1, 16'h0020, 12'h222, 16'h0020);
    cycle("coll",   1'b1, 1'b0, 16'h0000, 12'h000, 16'h0020);

    cycle("bound",  1'b1, 1'b1, 16'h0000, 12'hFFF, 16'h0010);
    cycle("bound",  1'b1, 1'b1, 16'hFFFF, 12'h001, 16'h0010);
    cycle("b2b",    1'b1, 1'b0, 16'h0000, 12'h000, 16'h0000);
    cycle("b2b",    1'b1, 1'b0, 16'h0000, 12'h000, 16'hFFFF);
    cycle("b2b",    1'b1, 1'b0, 16'h0000, 12'h000, 16'h0000);

    cycle("gate",   1'b1, 1'b0, 16'h0030, 12'h555, 16'h0030);
    cycle("gate",   1'b1, 1'b0, 16'h0000, 12'h000, 16'h0030);

    // Mid-cycle reset pulse must clear rd_data without a clock edge.
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("rst_async_mid", bus.rd_data, '0);
    cycle("rst_mid", 1'b0, 1'b1, 16'h0010, 12'h999, 16'h0010);
    cycle("rst_mid", 1'b0, 1'b0, 16'h0000, 12'h000, 16'h0010);
    cycle("retain",  1'b1, 1'b0, 16'h0000, 12'h000, 16'h0010);
    cycle("retain",  1'b1, 1'b0, 16'h0000, 12'h000, 16'hFFFF);

    // Random traffic; a small address pool forces collisions and rereads.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) ra = wa;
      cycle("rand", 1'b1, 1'($urandom_range(0, 1)), wa, DW'($urandom), ra);
    end

    @(negedge clk);
    bus.wr_req = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
